// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the RISC-32 pipeline hazard controller.
// Contents:
//   state_t     - controller state (RUN, MC_WAIT)
//   STALL_CNT_W - width of the saturating stall-cycle counter
//   src_hit     - helper: one source operand collides with a destination
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    localparam int STALL_CNT_W = 16;

    // True when a used source register equals the destination register.
    function automatic logic src_hit(input logic used, input logic [7:0] rs, input logic [7:0] rd);
        return used & (rs == rd);
    endfunction

endpackage

// File: rtl/mc_down_counter.sv
// Down-counter that times the wait phase of a multi-cycle EX operation.
// Ports:
//   Clk      in   clock
//   Rst_n    in   synchronous active-low reset (counter -> 0)
//   load     in   load load_val (multi-cycle op issues)
//   load_val in   value to load (MC_LAT-1)
//   dec      in   decrement by one (controller waiting)
//   cnt      out  registered count
//   tc       out  terminal count: last wait cycle (cnt == 1)
module mc_down_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-32 pipeline (IF, OF, EX, MA, RW).
// Each cycle it decides whether IF/OF and OF/EX load, hold or take a bubble
// and whether the PC advances, covering load-use stalls, taken-branch
// flushes resolved in EX and multi-cycle (mul/div) EX occupancy. A
// saturating counter records cycles in which the PC did not advance.
// Ports:
//   Clk, Rst_n             clock, synchronous active-low reset
//   of_rs1/of_rs2          OF source registers, of_use_rs1/2 their valid bits
//   of_is_mc               OF instruction is multi-cycle
//   ex_is_load, ex_rd      EX instruction is a load, its destination
//   ex_branch_taken        EX resolved a taken branch this cycle
//   pc_en, if_of_en        PC and IF/OF load enables
//   if_of_flush            IF/OF loads a NOP (wins over if_of_en)
//   of_ex_bubble           OF/EX loads a NOP
//   ex_hold                OF/EX and EX state hold
//   ex_ma_bubble           EX/MA loads a NOP
//   mc_busy                waiting on a multi-cycle op
//   stall_cnt              saturating count of cycles with pc_en=0
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int MC_LAT = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [REG_AW-1:0]      of_rs1,
    input  logic [REG_AW-1:0]      of_rs2,
    input  logic                   of_use_rs1,
    input  logic                   of_use_rs2,
    input  logic                   of_is_mc,
    input  logic                   ex_is_load,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   ex_branch_taken,
    output logic                   pc_en,
    output logic                   if_of_en,
    output logic                   if_of_flush,
    output logic                   of_ex_bubble,
    output logic                   ex_hold,
    output logic                   ex_ma_bubble,
    output logic                   mc_busy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [3:0]             MC_LOAD   = 4'(MC_LAT - 1);
    localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

    state_t                   state_r;
    logic [STALL_CNT_W-1:0]   stall_cnt_r;
    logic                     lu_s;
    logic                     mc_load_s;
    logic                     mc_dec_s;
    logic                     mc_tc_s;
    logic [3:0]               mc_cnt_s;
    logic [7:0]               rs1_s;
    logic [7:0]               rs2_s;
    logic [7:0]               rd_s;

    assign rs1_s = 8'(of_rs1);
    assign rs2_s = 8'(of_rs2);
    assign rd_s  = 8'(ex_rd);

    // Load-use: the OF instruction needs the value a load in EX is still fetching.
    assign lu_s = ex_is_load & (src_hit(of_use_rs1, rs1_s, rd_s) | src_hit(of_use_rs2, rs2_s, rd_s));

    // A multi-cycle op issues only in RUN when neither a flush nor a stall wins.
    assign mc_load_s = Rst_n & (state_r == RUN) & ~ex_branch_taken & ~lu_s & of_is_mc;
    assign mc_dec_s  = Rst_n & (state_r == MC_WAIT);

    mc_down_counter #(
        .W (4)
    ) u_mc_cnt (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .load     (mc_load_s),
        .load_val (MC_LOAD),
        .dec      (mc_dec_s),
        .cnt      (mc_cnt_s),
        .tc       (mc_tc_s)
    );

    // Priority decode of pipeline enables/bubbles from state and current inputs.
    always_comb begin
        pc_en        = 1'b1;
        if_of_en     = 1'b1;
        if_of_flush  = 1'b0;
        of_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        ex_ma_bubble = 1'b0;
        mc_busy      = 1'b0;
        if (!Rst_n) begin
            pc_en        = 1'b0;
            if_of_en     = 1'b0;
            if_of_flush  = 1'b1;
            of_ex_bubble = 1'b1;
            ex_ma_bubble = 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (ex_branch_taken) begin
                        // Wrong-path OF instruction: squash it regardless of lu/mc.
                        if_of_flush  = 1'b1;
                        of_ex_bubble = 1'b1;
                    end else if (lu_s) begin
                        pc_en        = 1'b0;
                        if_of_en     = 1'b0;
                        of_ex_bubble = 1'b1;
                    end else begin
                        pc_en        = 1'b1;
                    end
                end
                MC_WAIT: begin
                    pc_en        = 1'b0;
                    if_of_en     = 1'b0;
                    ex_hold      = 1'b1;
                    ex_ma_bubble = 1'b1;
                    mc_busy      = 1'b1;
                end
                default: begin
                    pc_en        = 1'b0;
                    if_of_en     = 1'b0;
                    if_of_flush  = 1'b1;
                    of_ex_bubble = 1'b1;
                    ex_ma_bubble = 1'b1;
                end
            endcase
        end
    end

    // Controller FSM: RUN until a multi-cycle op issues, back on terminal count.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: begin
                    if (mc_load_s) begin
                        state_r <= MC_WAIT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                MC_WAIT: begin
                    if (mc_tc_s) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= MC_WAIT;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (!pc_en && (stall_cnt_r != STALL_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MC_LAT=4): table of input/expected
// records applied in a loop, plus hand-written reset and saturation sequences.
// Expected records are queued when stimulus is driven and popped at the
// falling edge, where the combinational outputs and stall_cnt are compared.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       use1;
        logic       use2;
        logic       is_mc;
        logic       is_load;
        logic [3:0] rd;
        logic       br;
    } vin_t;

    typedef struct packed {
        logic        pc_en;
        logic        if_of_en;
        logic        flush;
        logic        of_ex_bubble;
        logic        ex_hold;
        logic        ex_ma_bubble;
        logic        mc_busy;
        logic [15:0] cnt;
    } vexp_t;

    typedef struct {
        vin_t  vi;
        vexp_t ve;
        string name;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  of_rs1;
    logic [3:0]  of_rs2;
    logic        of_use_rs1;
    logic        of_use_rs2;
    logic        of_is_mc;
    logic        ex_is_load;
    logic [3:0]  ex_rd;
    logic        ex_branch_taken;
    logic        pc_en;
    logic        if_of_en;
    logic        if_of_flush;
    logic        of_ex_bubble;
    logic        ex_hold;
    logic        ex_ma_bubble;
    logic        mc_busy;
    logic [15:0] stall_cnt;

    int    errors = 0;
    int    checks = 0;
    vexp_t sb_q[$];
    vec_t  tbl[$];

    pipe_hazard_ctrl #(
        .REG_AW (4),
        .MC_LAT (4)
    ) dut (
        .Clk             (clk),
        .Rst_n           (rst_n),
        .of_rs1          (of_rs1),
        .of_rs2          (of_rs2),
        .of_use_rs1      (of_use_rs1),
        .of_use_rs2      (of_use_rs2),
        .of_is_mc        (of_is_mc),
        .ex_is_load      (ex_is_load),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .pc_en           (pc_en),
        .if_of_en        (if_of_en),
        .if_of_flush     (if_of_flush),
        .of_ex_bubble    (of_ex_bubble),
        .ex_hold         (ex_hold),
        .ex_ma_bubble    (ex_ma_bubble),
        .mc_busy         (mc_busy),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input shorthands: normal, load-use on rs2 (rd=5), load-use on rs1 (rd=3).
    function automatic vin_t in_norm(input logic mc, input logic br);
        vin_t v;
        v = '0;
        v.rst_n = 1'b1; v.rs1 = 4'd1; v.rs2 = 4'd2; v.rd = 4'd7; v.is_mc = mc; v.br = br;
        return v;
    endfunction

    function automatic vin_t in_lu2(input logic mc, input logic br);
        vin_t v;
        v = in_norm(mc, br);
        v.is_load = 1'b1; v.rd = 4'd5; v.rs2 = 4'd5; v.use2 = 1'b1;
        return v;
    endfunction

    function automatic vin_t in_lu1(input logic mc);
        vin_t v;
        v = in_norm(mc, 1'b0);
        v.is_load = 1'b1; v.rd = 4'd3; v.rs1 = 4'd3; v.use1 = 1'b1;
        return v;
    endfunction

    // Expected shorthands: {pc,if,flush,bub,hold,mab,busy,cnt}.
    function automatic vexp_t e_norm(input logic [15:0] c);
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c};
    endfunction
    function automatic vexp_t e_lu(input logic [15:0] c);
        return {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, c};
    endfunction
    function automatic vexp_t e_br(input logic [15:0] c);
        return {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, c};
    endfunction
    function automatic vexp_t e_wait(input logic [15:0] c);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, c};
    endfunction
    function automatic vexp_t e_rst(input logic [15:0] c);
        return {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, c};
    endfunction

    task automatic drive(input vin_t v);
        rst_n           = v.rst_n;
        of_rs1          = v.rs1;
        of_rs2          = v.rs2;
        of_use_rs1      = v.use1;
        of_use_rs2      = v.use2;
        of_is_mc        = v.is_mc;
        ex_is_load      = v.is_load;
        ex_rd           = v.rd;
        ex_branch_taken = v.br;
    endtask

    // Drive one cycle, queue its expectation, compare at the falling edge.
    task automatic step(input vin_t v, input vexp_t e, input string name, input logic do_check);
        vexp_t exp_v;
        vexp_t act_v;
        drive(v);
        if (do_check) sb_q.push_back(e);
        @(negedge clk);
        if (do_check) begin
            exp_v = sb_q.pop_front();
            act_v = {pc_en, if_of_en, if_of_flush, of_ex_bubble, ex_hold, ex_ma_bubble, mc_busy, stall_cnt};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL %s: got pc=%b if=%b fl=%b bub=%b hold=%b mab=%b busy=%b cnt=%h, want pc=%b if=%b fl=%b bub=%b hold=%b mab=%b busy=%b cnt=%h",
                         name, act_v.pc_en, act_v.if_of_en, act_v.flush, act_v.of_ex_bubble, act_v.ex_hold,
                         act_v.ex_ma_bubble, act_v.mc_busy, act_v.cnt, exp_v.pc_en, exp_v.if_of_en, exp_v.flush,
                         exp_v.of_ex_bubble, exp_v.ex_hold, exp_v.ex_ma_bubble, exp_v.mc_busy, exp_v.cnt);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input vin_t v, input vexp_t e, input string name);
        vec_t t;
        t.vi = v; t.ve = e; t.name = name;
        tbl.push_back(t);
    endtask

    initial begin
        vin_t  rv;
        vin_t  rst_v;

        // Main table; expected stall_cnt tracks the pc_en=0 cycles before each row.
        add(in_norm(1'b0, 1'b0), e_norm(16'd0),  "run_normal");
        add(in_lu2(1'b0, 1'b0),  e_lu(16'd0),    "lu_rs2_stall");
        add(in_norm(1'b0, 1'b0), e_norm(16'd1),  "after_lu_normal");
        add(in_lu2(1'b0, 1'b1),  e_br(16'd1),    "branch_beats_lu");
        add(in_norm(1'b0, 1'b0), e_norm(16'd1),  "after_branch_cnt_same");
        rv = in_lu1(1'b0); rv.use1 = 1'b0;
        add(rv,                  e_norm(16'd1),  "match_but_unused_rs1");
        rv = in_lu1(1'b0); rv.is_load = 1'b0;
        add(rv,                  e_norm(16'd1),  "match_not_load");
        add(in_lu1(1'b0),        e_lu(16'd1),    "lu_rs1_stall");
        add(in_lu1(1'b1),        e_lu(16'd2),    "lu_with_mc_stall_wins");
        add(in_norm(1'b1, 1'b0), e_norm(16'd3),  "mc_issue");
        add(in_lu2(1'b0, 1'b1),  e_wait(16'd3),  "mc_wait1_ignores_br_lu");
        add(in_norm(1'b0, 1'b0), e_wait(16'd4),  "mc_wait2");
        add(in_norm(1'b0, 1'b0), e_wait(16'd5),  "mc_wait3");
        add(in_norm(1'b1, 1'b0), e_norm(16'd6),  "mc_back_to_back_issue");
        add(in_norm(1'b0, 1'b0), e_wait(16'd6),  "mc2_wait1");
        add(in_norm(1'b0, 1'b0), e_wait(16'd7),  "mc2_wait2");
        add(in_norm(1'b0, 1'b0), e_wait(16'd8),  "mc2_wait3");
        add(in_norm(1'b0, 1'b0), e_norm(16'd9),  "run_after_mc2");
        add(in_norm(1'b1, 1'b0), e_norm(16'd9),  "mc3_issue");
        add(in_norm(1'b0, 1'b0), e_wait(16'd9),  "mc3_wait1");
        rst_v = in_norm(1'b0, 1'b0); rst_v.rst_n = 1'b0;
        add(rst_v,               e_rst(16'd10),  "reset_in_mc_wait2");
        add(in_norm(1'b0, 1'b0), e_norm(16'd0),  "run_after_reset_abort");
        add(in_norm(1'b0, 1'b0), e_norm(16'd0),  "run_still_after_abort");

        // Reset held 3 cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            rv = vin_t'($urandom);
            rv.rst_n = 1'b0;
            step(rv, e_rst(16'd0), $sformatf("reset_cycle%0d", i), 1'b1);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].vi, tbl[i].ve, tbl[i].name, 1'b1);
        end

        // Saturation: hold a load-use stall; check just below and at the limit.
        for (int i = 0; i < 65534; i++) begin
            step(in_lu2(1'b0, 1'b0), e_lu(16'd0), "", 1'b0);
        end
        step(in_lu2(1'b0, 1'b0), e_lu(16'hFFFE), "sat_fffe", 1'b1);
        step(in_lu2(1'b0, 1'b0), e_lu(16'hFFFF), "sat_reach_ffff", 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(in_lu2(1'b0, 1'b0), e_lu(16'd0), "", 1'b0);
        end
        step(in_lu2(1'b0, 1'b0), e_lu(16'hFFFF), "sat_hold_lu", 1'b1);
        step(in_norm(1'b1, 1'b0), e_norm(16'hFFFF), "sat_mc_issue", 1'b1);
        step(in_norm(1'b0, 1'b0), e_wait(16'hFFFF), "sat_mc_wait1", 1'b1);
        step(in_norm(1'b0, 1'b0), e_wait(16'hFFFF), "sat_mc_wait2", 1'b1);
        step(in_norm(1'b0, 1'b0), e_wait(16'hFFFF), "sat_mc_wait3", 1'b1);
        step(in_norm(1'b0, 1'b0), e_norm(16'hFFFF), "sat_run_after_mc", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
